// File: rtl/sampler_pkg.sv
// Shared analyzer constants: demux channel geometry and sampler defaults.
// The sampler data bus is the full demultiplexed channel bus.
package sampler_pkg;

    localparam int DEMUX_CHANNELS      = 4;
    localparam int DEMUX_CHANNEL_WIDTH = 8;

    localparam int DATA_WIDTH_DEFAULT  = DEMUX_CHANNELS * DEMUX_CHANNEL_WIDTH;
    localparam int DIV_WIDTH_DEFAULT   = 24;

    // What the sampler does in a given cycle, in priority order.
    typedef enum logic [1:0] {
        ACT_CONFIG,
        ACT_BYPASS,
        ACT_DIVIDE,
        ACT_IDLE
    } sampler_action_t;

endpackage

// File: rtl/sampler.sv
// Sample decimator: passes one valid input sample in every (div+1), or all
// samples in external-clock bypass, plus a half-period marker for downstream.
module sampler
    import sampler_pkg::*;
#(
    parameter int DIV_WIDTH  = DIV_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ext_clock_mode,
    input  logic                  wr_divider,
    input  logic [DIV_WIDTH-1:0]  config_data,
    input  logic                  sti_valid,
    input  logic [DATA_WIDTH-1:0] sti_data,
    output logic                  sto_valid,
    output logic [DATA_WIDTH-1:0] sto_data,
    output logic                  ready50
);

    logic [DIV_WIDTH-1:0]  div_reg, div_next;
    logic [DIV_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [DIV_WIDTH-1:0]  half_div;
    logic                  valid_reg, valid_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  ready50_reg, ready50_next;
    sampler_action_t       action;

    assign half_div = div_reg >> 1;

    always_comb begin
        if (wr_divider)
            action = ACT_CONFIG;
        else if (ext_clock_mode)
            action = ACT_BYPASS;
        else if (sti_valid)
            action = ACT_DIVIDE;
        else
            action = ACT_IDLE;
    end

    always_comb begin
        div_next     = div_reg;
        cnt_next     = cnt_reg;
        valid_next   = 1'b0;
        data_next    = data_reg;
        ready50_next = ready50_reg;

        case (action)
            // A coincident input sample is dropped; the new ratio starts clean.
            ACT_CONFIG: begin
                div_next     = config_data;
                cnt_next     = '0;
                ready50_next = 1'b0;
            end
            // Data only moves with a valid strobe so sto_data holds while idle.
            ACT_BYPASS: begin
                valid_next = sti_valid;
                if (sti_valid)
                    data_next = sti_data;
            end
            ACT_DIVIDE: begin
                if (cnt_reg == '0) begin
                    valid_next   = 1'b1;
                    data_next    = sti_data;
                    cnt_next     = div_reg;
                    ready50_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - DIV_WIDTH'(1);
                    if (cnt_reg == half_div)
                        ready50_next = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_reg     <= '0;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
            data_reg    <= '0;
            ready50_reg <= 1'b0;
        end else begin
            div_reg     <= div_next;
            cnt_reg     <= cnt_next;
            valid_reg   <= valid_next;
            data_reg    <= data_next;
            ready50_reg <= ready50_next;
        end
    end

    assign sto_valid = valid_reg;
    assign sto_data  = data_reg;
    assign ready50   = ready50_reg;

endmodule

// File: tb/tb_sampler.sv
// Directed bench for the sampler: pass-through, decimation, gaps, config
// collision, async reset, bypass and the maximum divider.
module tb_sampler;

    localparam int DW = 24;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          ext_clock_mode;
    logic          wr_divider;
    logic [DW-1:0] config_data;
    logic          sti_valid;
    logic [AW-1:0] sti_data;
    logic          sto_valid;
    logic [AW-1:0] sto_data;
    logic          ready50;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] last_data;

    sampler #(.DIV_WIDTH(DW), .DATA_WIDTH(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .ext_clock_mode (ext_clock_mode),
        .wr_divider     (wr_divider),
        .config_data    (config_data),
        .sti_valid      (sti_valid),
        .sti_data       (sti_data),
        .sto_valid      (sto_valid),
        .sto_data       (sto_data),
        .ready50        (ready50)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle 1 time unit after the edge.
    task automatic step(input logic wr, input logic [DW-1:0] cfg, input logic ext,
                        input logic v, input logic [AW-1:0] d);
        wr_divider     = wr;
        config_data    = cfg;
        ext_clock_mode = ext;
        sti_valid      = v;
        sti_data       = d;
        @(posedge clock);
        #1;
    endtask

    // Check one divide/bypass output cycle against expected strobe, data and marker.
    task automatic expect_out(input string tag, input logic v, input logic [AW-1:0] d, input logic r);
        check({tag, ".valid"}, 64'(sto_valid), 64'(v));
        if (v) last_data = d;
        check({tag, ".data"}, 64'(sto_data), 64'(last_data));
        check({tag, ".ready50"}, 64'(ready50), 64'(r));
        $display("txn %s: valid=%0d data=0x%0h ready50=%0d", tag, sto_valid, sto_data, ready50);
    endtask

    task automatic write_div(input logic [DW-1:0] value);
        step(1'b1, value, 1'b0, 1'b0, '0);
        expect_out("wr_div", 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] d;
        reset = 1'b1;
        wr_divider = 1'b0; config_data = '0; ext_clock_mode = 1'b0;
        sti_valid = 1'b0; sti_data = '0;
        last_data = '0;
        repeat (2) @(posedge clock);
        #3;
        check("reset.valid", 64'(sto_valid), 64'd0);
        check("reset.data", 64'(sto_data), 64'd0);
        check("reset.ready50", 64'(ready50), 64'd0);
        reset = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, '0);
        expect_out("release", 1'b0, '0, 1'b0);

        // Pass-through with div=0.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, AW'(i));
            expect_out($sformatf("pass%0d", i), 1'b1, AW'(i), 1'b1);
        end
        step(1'b0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        expect_out("pass_idle", 1'b0, '0, 1'b1);

        // Decimate by 4.
        write_div(24'd3);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, AW'(i));
            expect_out($sformatf("dec4_%0d", i), (i % 4) == 0, AW'(i), (i % 4) != 3);
        end

        // Gapped input, div=2.
        write_div(24'd2);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 32'hA0 + AW'(i));
            expect_out($sformatf("gap_%0d", i), (i % 3) == 0, 32'hA0 + AW'(i), (i % 3) != 2);
            step(1'b0, '0, 1'b0, 1'b0, 32'h5555_5555);
            expect_out($sformatf("gap_idle%0d", i), 1'b0, '0, (i % 3) != 2);
        end

        // Collision: config write with a coincident valid sample, cnt=3.
        write_div(24'd5);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 32'hC0 + AW'(i));
            expect_out($sformatf("col_pre%0d", i), i == 0, 32'hC0 + AW'(i), 1'b1);
        end
        step(1'b1, 24'd1, 1'b0, 1'b1, 32'h0000_00EE);
        expect_out("col_x", 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h0000_00F1);
        expect_out("col_y", 1'b1, 32'hF1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 32'h0000_00F2);
        expect_out("col_skip", 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 32'h0000_00F3);
        expect_out("col_next", 1'b1, 32'hF3, 1'b1);

        // Asynchronous reset mid-period with div=9, cnt=4.
        write_div(24'd9);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 32'hB0 + AW'(i));
            expect_out($sformatf("rst_pre%0d", i), i == 0, 32'hB0 + AW'(i), 1'b1);
        end
        #2 reset = 1'b1;
        #1;
        check("async_rst.valid", 64'(sto_valid), 64'd0);
        check("async_rst.data", 64'(sto_data), 64'd0);
        check("async_rst.ready50", 64'(ready50), 64'd0);
        last_data = '0;
        @(posedge clock);
        #2 reset = 1'b0;
        sti_valid = 1'b0;
        @(posedge clock);
        #1;
        expect_out("rst_release", 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 32'hD0 + AW'(i));
            expect_out($sformatf("rst_post%0d", i), 1'b1, 32'hD0 + AW'(i), 1'b1);
        end

        // Bypass with div=7, cnt=6 held across it.
        write_div(24'd7);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 32'hE0 + AW'(i));
            expect_out($sformatf("byp_pre%0d", i), i == 0, 32'hE0 + AW'(i), 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 32'h100 + AW'(i));
            expect_out($sformatf("byp_%0d", i), 1'b1, 32'h100 + AW'(i), 1'b1);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 32'h200 + AW'(i));
            expect_out($sformatf("byp_resume%0d", i), i == 6, 32'h200 + AW'(i), (i < 3) || (i == 6));
        end

        // Maximum divider: counter loads all-ones without overflow.
        write_div({DW{1'b1}});
        d = 32'h0000_0ABC;
        step(1'b0, '0, 1'b0, 1'b1, d);
        expect_out("max_emit", 1'b1, d, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, d + AW'(i) + 1);
            expect_out($sformatf("max_hold%0d", i), 1'b0, '0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sampler.md
SAMPLER -- requirements
Module: sampler

Interface
REQ-001 Parameter DIV_WIDTH, default 24, sets the width of the divider register and the down-counter.
REQ-002 Parameter DATA_WIDTH, default 32, sets the sample width and matches the demultiplexed channel bus.
REQ-003 `clock`  input  1  sole clock; all state updates on its rising edge.
REQ-004 `reset`  input  1  asynchronous, active-high reset.
REQ-005 `ext_clock_mode`  input  1  1 = bypass decimation (external/demux clocking); 0 = divide.
REQ-006 `wr_divider`  input  1  single-cycle strobe that loads the divider from `config_data`.
REQ-007 `config_data`  input  DIV_WIDTH  new divider value, sampled when `wr_divider`=1.
REQ-008 `sti_valid`  input  1  input sample strobe from the demux/sync stage.
REQ-009 `sti_data`  input  DATA_WIDTH  input sample.
REQ-010 `sto_valid`  output  1  registered output sample strobe.
REQ-011 `sto_data`  output  DATA_WIDTH  registered output sample.
REQ-012 `ready50`  output  1  registered half-period marker for the downstream trigger/RLE stage.

Function
REQ-013 The block SHALL hold internal registers `div` (DIV_WIDTH) and `cnt` (DIV_WIDTH), both unsigned.
REQ-014 All outputs SHALL be registered, with exactly one clock of latency from the qualifying input cycle.
REQ-015 Priority per cycle SHALL be: reset, then `wr_divider`, then `ext_clock_mode`, then the divide logic.
REQ-016 On `wr_divider`=1, the block SHALL apply all of the following in that cycle:
- `div` <= `config_data`
- `cnt` <= 0
- `sto_valid` <= 0
- `ready50` <= 0
- any coincident `sti_valid` sample is dropped.
REQ-017 When `ext_clock_mode`=1, the block SHALL register `sto_valid` <= `sti_valid` and `sto_data` <= `sti_data` every cycle, and leave `cnt` and `ready50` unchanged.
REQ-018 Divide mode, `sti_valid`=1 and `cnt`=0: the block SHALL emit (`sto_valid` <= 1, `sto_data` <= `sti_data`), set `cnt` <= `div`, and set `ready50` <= 1.
REQ-019 Divide mode, `sti_valid`=1 and `cnt`!=0: the block SHALL set `cnt` <= `cnt`-1 and `sto_valid` <= 0.
REQ-020 Divide mode, `sti_valid`=0: the block SHALL hold `cnt` and `ready50`, and set `sto_valid` <= 0.
REQ-021 The block SHALL clear `ready50` on any divide-mode cycle with `sti_valid`=1, `cnt`!=0 and `cnt` == (`div` >> 1).
REQ-022 Output rate SHALL be exactly one sample per (`div`+1) valid input samples; `div`=0 passes every valid sample.
REQ-023 `cnt` SHALL never wrap below 0.
REQ-024 `div`=2^DIV_WIDTH-1 SHALL work without overflow.
REQ-025 `sto_data` SHALL hold its last value whenever `sto_valid`=0.
REQ-026 A `div` change SHALL take effect at the first valid sample after the write; that sample is emitted immediately because `cnt`=0.
REQ-027 Toggling `ext_clock_mode` 1->0 SHALL resume division from the held `cnt`, with no forced restart.

Reset
REQ-028 On `reset`=1, asynchronously, the block SHALL set `div`=0, `cnt`=0, `sto_valid`=0, `sto_data`=0 and `ready50`=0.
REQ-029 Reset mid-period SHALL discard the partial count; after release, the first valid sample SHALL be emitted.
REQ-030 Reset release SHALL NOT itself generate `sto_valid`.

Structure
REQ-031 DIV_WIDTH and DATA_WIDTH defaults SHALL live in the shared analyzer constants package alongside the demux channel-width constants.
REQ-032 The block SHALL be a single module with no sub-modules; the counter and divider are inline registers.

Verification
REQ-033 Pass-through:
- stimulus: `div`=0, `ext_clock_mode`=0, 8 back-to-back valid samples 0x00000001..0x00000008.
- response: 8 `sto_valid` pulses with identical data, each one cycle late; `ready50` stays 1.
REQ-034 Decimate by 4:
- stimulus: `wr_divider` with `config_data`=3, then 12 consecutive valid samples 0..11.
- response: outputs 0, 4 and 8 only.
- `ready50` rises with each output and falls on the valid cycle where `cnt`=1.
REQ-035 Gapped input:
- stimulus: `div`=2; valid asserted on alternate cycles for samples A, B, C, D, E, F, G.
- response: outputs A, D, G; `cnt` holds during idle cycles.
REQ-036 Collision:
- stimulus: `div`=5, period running with `cnt`=3; `wr_divider` with `config_data`=1 in the same cycle as `sti_valid`=1 carrying data X.
- response: X dropped; the next valid sample Y is emitted; the sample after Y is skipped and the next one emitted.
REQ-037 Reset:
- stimulus: `div`=9; assert `reset` asynchronously mid-cycle with `cnt`=4.
- response: all outputs 0 immediately; after release `div`=0, so every valid sample passes.
REQ-038 Bypass:
- stimulus: `div`=7, `ext_clock_mode`=1, 5 valid samples; then `ext_clock_mode`=0.
- response: all 5 samples passed; division then resumes from the held `cnt`.
